// File: rtl/decode_pkg.sv
// Shared defaults for the decode stage: widths, the hard-wired zero register and
// the ID/EX bundle layout at default widths.
package decode_pkg;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int IMM_W    = 6;
  localparam int FUNCT_W  = 2;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic [FUNCT_W-1:0] funct;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  dest;
    logic [DATA_W-1:0]  ext;
    logic [DATA_W-1:0]  data2;
    logic [DATA_W-1:0]  data1;
  } idex_t;
endpackage

// File: rtl/decode_regfile.sv
// Register file with r0 hard-wired to zero, two combinational reads, one write.
// DECODE_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module decode_regfile #(
  parameter int DATA_W = decode_pkg::DATA_W,
  parameter int REG_AW = decode_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              wbEn,
  input  logic [REG_AW-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);
  import decode_pkg::*;

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] r_mem [2**REG_AW];
  logic              w_wr_ok;

  assign w_wr_ok = wbEn && (wbAddr != ZERO_ADDR);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2**REG_AW; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wbAddr] <= wbData;
    end
  end

  always_comb begin
    rdData1 = (rs == ZERO_ADDR) ? '0 : r_mem[rs];
    rdData2 = (rt == ZERO_ADDR) ? '0 : r_mem[rt];
`ifdef DECODE_BYPASS_EN
    if (w_wr_ok && wbAddr == rs) rdData1 = wbData;
    if (w_wr_ok && wbAddr == rt) rdData2 = wbData;
`endif
  end
endmodule

// File: rtl/decode_stage.sv
// ID stage: register read, immediate extension, destination select, load-use
// bubble and the ID/EX register. DECODE_BYPASS_EN enables writeback bypass.
module decode_stage #(
  parameter int DATA_W  = decode_pkg::DATA_W,
  parameter int REG_AW  = decode_pkg::REG_AW,
  parameter int IMM_W   = decode_pkg::IMM_W,
  parameter int FUNCT_W = decode_pkg::FUNCT_W
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               inValid,
  input  logic [REG_AW-1:0]  rs,
  input  logic [REG_AW-1:0]  rt,
  input  logic [REG_AW-1:0]  rd,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [IMM_W-1:0]   imm,
  input  logic               regWrite,
  input  logic               regDst,
  input  logic               memRead,
  input  logic               extZero,
  input  logic               wbEn,
  input  logic [REG_AW-1:0]  wbAddr,
  input  logic [DATA_W-1:0]  wbData,
  input  logic               exStall,
  input  logic               flush,
  output logic               stall,
  output logic               outValid,
  output logic [DATA_W-1:0]  readData1,
  output logic [DATA_W-1:0]  readData2,
  output logic [DATA_W-1:0]  extendedSignal,
  output logic [REG_AW-1:0]  destReg,
  output logic [REG_AW-1:0]  outRs,
  output logic [REG_AW-1:0]  outRt,
  output logic [FUNCT_W-1:0] outFunct,
  output logic               outRegWrite,
  output logic               outMemRead
);
  import decode_pkg::*;

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_ext;
  logic [REG_AW-1:0] w_dest;
  logic              w_fill;
  logic              w_hazard;

  decode_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
    .clock   (clock),
    .resetN  (resetN),
    .rs      (rs),
    .rt      (rt),
    .wbEn    (wbEn),
    .wbAddr  (wbAddr),
    .wbData  (wbData),
    .rdData1 (w_rd1),
    .rdData2 (w_rd2)
  );

  assign w_fill = ~extZero & imm[IMM_W-1];
  assign w_ext  = {{(DATA_W-IMM_W){w_fill}}, imm};
  assign w_dest = regDst ? rd : rt;

  // Compared against the load currently held in EX, not the incoming fields.
  assign w_hazard = inValid & outValid & outMemRead & (destReg != ZERO_ADDR) &
                    ((destReg == rs) | (destReg == rt));
  assign stall    = (w_hazard | exStall) & ~flush;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outValid       <= 1'b0;
      outRegWrite    <= 1'b0;
      outMemRead     <= 1'b0;
      outFunct       <= '0;
      outRs          <= '0;
      outRt          <= '0;
      destReg        <= '0;
      readData1      <= '0;
      readData2      <= '0;
      extendedSignal <= '0;
    end else if (flush) begin
      outValid    <= 1'b0;
      outRegWrite <= 1'b0;
      outMemRead  <= 1'b0;
    end else if (exStall) begin
      outValid <= outValid;
    end else if (w_hazard) begin
      outValid    <= 1'b0;
      outRegWrite <= 1'b0;
      outMemRead  <= 1'b0;
    end else begin
      outValid       <= inValid;
      outRegWrite    <= inValid & regWrite;
      outMemRead     <= inValid & memRead;
      outFunct       <= funct;
      outRs          <= rs;
      outRt          <= rt;
      destReg        <= w_dest;
      readData1      <= w_rd1;
      readData2      <= w_rd2;
      extendedSignal <= w_ext;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; expected values are hand-computed constants.
module tb_decode_stage;
  logic        clock = 1'b0;
  logic        resetN = 1'b1;
  logic        inValid, regWrite, regDst, memRead, extZero, wbEn, exStall, flush;
  logic [2:0]  rs, rt, rd, wbAddr;
  logic [1:0]  funct;
  logic [5:0]  imm;
  logic [15:0] wbData;
  logic        stall, outValid, outRegWrite, outMemRead;
  logic [15:0] readData1, readData2, extendedSignal;
  logic [2:0]  destReg, outRs, outRt;
  logic [1:0]  outFunct;

  int n_vec = 0;
  int n_bad = 0;

  decode_stage dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm(imm), .regWrite(regWrite), .regDst(regDst), .memRead(memRead),
    .extZero(extZero), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .exStall(exStall), .flush(flush), .stall(stall), .outValid(outValid),
    .readData1(readData1), .readData2(readData2), .extendedSignal(extendedSignal),
    .destReg(destReg), .outRs(outRs), .outRt(outRt), .outFunct(outFunct),
    .outRegWrite(outRegWrite), .outMemRead(outMemRead)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    inValid = 0; regWrite = 0; regDst = 0; memRead = 0; extZero = 0;
    wbEn = 0; exStall = 0; flush = 0;
    rs = 0; rt = 0; rd = 0; wbAddr = 0; funct = 0; imm = 0; wbData = 0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                       input logic dst, input logic ld);
    inValid = 1; rs = a; rt = b; rd = d; regDst = dst; memRead = ld; regWrite = 1;
  endtask

  initial begin
    idle();
    #3 resetN = 0;
    #1;
    check_eq("rst_valid", outValid, 0);
    check_eq("rst_rd1", readData1, 0);
    check_eq("rst_stall", stall, 0);
    @(negedge clock) resetN = 1;

    // write r3, read it back
    wbEn = 1; wbAddr = 3; wbData = 16'h1234;
    tick();
    wbEn = 0; issue(3, 0, 0, 0, 0);
    tick();
    check_eq("wr_rd_r3", readData1, 16'h1234);
    check_eq("wr_rd_r0", readData2, 0);
    check_eq("wr_valid", outValid, 1);

    // writes to r0 are discarded
    inValid = 0; wbEn = 1; wbAddr = 0; wbData = 16'hFFFF;
    tick();
    wbEn = 0; issue(0, 0, 0, 0, 0);
    tick();
    check_eq("r0_zero", readData1, 0);

    // extension and destination select
    issue(0, 2, 5, 1, 0); imm = 6'b100001; extZero = 0;
    tick();
    check_eq("ext_sign", extendedSignal, 16'hFFE1);
    check_eq("dest_rd", destReg, 5);
    extZero = 1; regDst = 0;
    tick();
    check_eq("ext_zero", extendedSignal, 16'h0021);
    check_eq("dest_rt", destReg, 2);
    extZero = 0; imm = 0;

    // load-use hazard: one bubble
    issue(1, 4, 0, 0, 1);
    tick();
    check_eq("ld_memrd", outMemRead, 1);
    check_eq("ld_dest", destReg, 4);
    issue(4, 1, 6, 1, 0);
    #1 check_eq("hz_stall", stall, 1);
    tick();
    check_eq("hz_bubble", outValid, 0);
    check_eq("hz_bub_mr", outMemRead, 0);
    check_eq("hz_stall_clr", stall, 0);
    tick();
    check_eq("hz_cons_v", outValid, 1);
    check_eq("hz_cons_rs", outRs, 4);
    check_eq("hz_cons_dst", destReg, 6);

    // load to r0 never stalls
    issue(1, 0, 0, 0, 1);
    tick();
    issue(0, 1, 2, 1, 0);
    #1 check_eq("ld_r0_stall", stall, 0);
    tick();
    check_eq("ld_r0_valid", outValid, 1);

    // exStall holds ID/EX for three cycles
    issue(3, 4, 7, 1, 0); funct = 2; imm = 5;
    tick();
    check_eq("xs_pre_dst", destReg, 7);
    exStall = 1; issue(0, 0, 1, 1, 0); funct = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("xs_stall", stall, 1);
      tick();
      check_eq("xs_dst", destReg, 7);
      check_eq("xs_rd1", readData1, 16'h1234);
      check_eq("xs_funct", outFunct, 2);
      check_eq("xs_ext", extendedSignal, 16'h0005);
    end
    exStall = 0;
    tick();
    check_eq("xs_rel_dst", destReg, 1);
    check_eq("xs_rel_fn", outFunct, 1);
    funct = 0; imm = 0;

    // flush during a hazard
    issue(1, 4, 0, 0, 1);
    tick();
    issue(4, 0, 0, 0, 0); flush = 1;
    #1 check_eq("fl_stall", stall, 0);
    tick();
    check_eq("fl_valid", outValid, 0);
    check_eq("fl_regwr", outRegWrite, 0);
    flush = 0;

    // same-cycle writeback and read of r6
    inValid = 0; wbEn = 1; wbAddr = 6; wbData = 16'h1111;
    tick();
    wbData = 16'hBEEF; issue(6, 0, 0, 0, 0);
    tick();
`ifdef DECODE_BYPASS_EN
    check_eq("byp_rd1", readData1, 16'hBEEF);
`else
    check_eq("byp_rd1", readData1, 16'h1111);
`endif
    wbEn = 0;
    tick();
    check_eq("post_wb_rd1", readData1, 16'hBEEF);

    // reset in the middle of a load-use stall
    issue(1, 3, 0, 0, 1);
    tick();
    issue(3, 0, 0, 0, 0);
    #1 check_eq("rs_pre_stall", stall, 1);
    #1 resetN = 0;
    #1;
    check_eq("rs_valid", outValid, 0);
    check_eq("rs_memrd", outMemRead, 0);
    check_eq("rs_dest", destReg, 0);
    check_eq("rs_rd1", readData1, 0);
    check_eq("rs_stall", stall, 0);
    @(negedge clock) resetN = 1;
    issue(3, 6, 0, 0, 0);
    tick();
    check_eq("rs_r3_zero", readData1, 0);
    check_eq("rs_r6_zero", readData2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
